spawn_task_issuer: RTL and testbench

//  Accelerator-side end of the spawn queues: AXI master that publishes new tasks into the

---
 rtl/spawn_task_issuer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_spawn_task_issuer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spawn_task_issuer.sv
// spawn_task_issuer: AXI4-Lite master that publishes tasks into the
// spawn-out (SO) ring and drains completions from the spawn-in (SI) ring.
// Ports: clk, rstn (sync, active-low); task_* new-task handshake and fields;
//   pay_* payload word stream; fin_* completion handshake; err sticky
//   response error; busy (not idle); m_axi_* AXI4-Lite master (32b/64b).
// Optional: SPAWN_ISSUER_BACKOFF_EN adds a POLL_GAP wait after a failed poll.
module spawn_task_issuer #(
  parameter logic [31:0] SO_OFFSET = 32'h0,
  parameter logic [31:0] SI_OFFSET = 32'h0,
  parameter int unsigned SO_LEN    = 64,
  parameter int unsigned SI_LEN    = 48,
  parameter int unsigned POLL_GAP  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        task_valid,
  output logic        task_ready,
  input  logic [63:0] task_tid,
  input  logic [63:0] task_ptid,
  input  logic [63:0] task_type,
  input  logic [7:0]  task_nargs,
  input  logic [7:0]  task_ndeps,
  input  logic [7:0]  task_ncops,
  input  logic        pay_valid,
  output logic        pay_ready,
  input  logic [63:0] pay_data,
  output logic        fin_valid,
  input  logic        fin_ready,
  output logic [63:0] fin_tid,
  output logic [63:0] fin_ptid,
  output logic        err,
  output logic        busy,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

`ifdef SPAWN_ISSUER_BACKOFF_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam logic [15:0] GAP_LD =
    GAP_EN ? 16'(POLL_GAP) : 16'd0;

  typedef enum logic [3:0] {
    S_IDLE, S_TASK_LATCH, S_SO_CHK_HDR, S_SO_CHK,
    S_PAY_GET, S_SO_WR, S_SO_BR, S_SO_WR_HDR,
    S_SO_BR_HDR, S_SI_RD_HDR, S_SI_RD_TID,
    S_SI_RD_PTID, S_FIN, S_SI_CLR, S_SI_BR
  } state_t;

  state_t state, state_nx;

  logic [10:0] k, nslots, slot_k;
  logic [63:0] tid_q, ptid_q, type_q, pay_q;
  logic [7:0]  nargs_q, ndeps_q, ncops_q;
  logic [31:0] so_idx, si_idx;
  logic [31:0] ring_slot, ring_base;
  logic        si_turn, ar_sent, addr_sent, data_sent;
  logic [15:0] gap_cnt;

  logic rd_st, wr_st, br_st, si_st;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic wr_done, slot_free, si_hdr_ok, poll_miss;

  assign rd_st = state inside {S_SO_CHK_HDR, S_SO_CHK,
    S_SI_RD_HDR, S_SI_RD_TID, S_SI_RD_PTID};
  assign wr_st = state inside {S_SO_WR, S_SO_WR_HDR,
    S_SI_CLR};
  assign br_st = state inside {S_SO_BR, S_SO_BR_HDR,
    S_SI_BR};
  assign si_st = state inside {S_SI_RD_HDR, S_SI_RD_TID,
    S_SI_RD_PTID, S_SI_CLR, S_SI_BR};

  assign m_axi_arvalid = rd_st && !ar_sent &&
    (gap_cnt == 16'd0);
  assign m_axi_rready  = rd_st && ar_sent;
  assign m_axi_awvalid = wr_st && !addr_sent;
  assign m_axi_wvalid  = wr_st && !data_sent;
  assign m_axi_bready  = br_st;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awprot  = 3'b000;

  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rready && m_axi_rvalid;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign b_hs  = m_axi_bready && m_axi_bvalid;

  // A write finishes once both channels have been accepted,
  // in whichever order the slave takes them.
  assign wr_done = (addr_sent || aw_hs) &&
    (data_sent || w_hs);

  assign slot_free = (m_axi_rdata[63:56] == 8'h00);
  assign si_hdr_ok = (m_axi_rdata[63:56] == 8'h80);
  assign poll_miss = r_hs &&
    (((state == S_SO_CHK_HDR || state == S_SO_CHK) &&
      !slot_free) ||
     (state == S_SI_RD_HDR && !si_hdr_ok));

  assign task_ready = (state == S_TASK_LATCH);
  assign pay_ready  = (state == S_PAY_GET);
  assign fin_valid  = (state == S_FIN);
  assign busy       = (state != S_IDLE);

  always_comb begin
    slot_k = 11'd0;
    unique case (state)
      S_SO_CHK, S_SO_WR, S_SO_BR: slot_k = k;
      S_SI_RD_TID:  slot_k = 11'd1;
      S_SI_RD_PTID: slot_k = 11'd2;
      default:      slot_k = 11'd0;
    endcase
  end

  // Wrap is applied per slot so a task may straddle the ring end.
  assign ring_slot = si_st ?
    (si_idx + 32'(slot_k)) % SI_LEN :
    (so_idx + 32'(slot_k)) % SO_LEN;
  assign ring_base = si_st ? SI_OFFSET : SO_OFFSET;
  assign m_axi_araddr = ring_base + (ring_slot << 3);
  assign m_axi_awaddr = m_axi_araddr;

  always_comb begin
    m_axi_wdata = pay_q;
    m_axi_wstrb = 8'hFF;
    unique case (1'b1)
      state == S_SI_CLR: begin
        m_axi_wdata = 64'h0;
        m_axi_wstrb = 8'h80;
      end
      state == S_SO_WR_HDR:
        m_axi_wdata = {8'h80, 24'h0, ncops_q,
          ndeps_q, nargs_q, 8'h00};
      state == S_SO_WR && k == 11'd1:
        m_axi_wdata = tid_q;
      state == S_SO_WR && k == 11'd2:
        m_axi_wdata = ptid_q;
      state == S_SO_WR && k == 11'd3:
        m_axi_wdata = type_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        state_nx = (task_valid && !si_turn) ?
          S_TASK_LATCH : S_SI_RD_HDR;
      S_TASK_LATCH: state_nx = S_SO_CHK_HDR;
      S_SO_CHK_HDR:
        if (r_hs && slot_free) state_nx = S_SO_CHK;
      S_SO_CHK:
        if (r_hs && slot_free)
          state_nx = (k < 11'd4) ? S_SO_WR : S_PAY_GET;
      S_PAY_GET:
        if (pay_valid) state_nx = S_SO_WR;
      S_SO_WR:
        if (wr_done) state_nx = S_SO_BR;
      S_SO_BR:
        if (b_hs)
          state_nx = (k == nslots - 11'd1) ?
            S_SO_WR_HDR : S_SO_CHK;
      S_SO_WR_HDR:
        if (wr_done) state_nx = S_SO_BR_HDR;
      S_SO_BR_HDR:
        if (b_hs) state_nx = S_IDLE;
      S_SI_RD_HDR:
        if (r_hs)
          state_nx = si_hdr_ok ? S_SI_RD_TID : S_IDLE;
      S_SI_RD_TID:
        if (r_hs) state_nx = S_SI_RD_PTID;
      S_SI_RD_PTID:
        if (r_hs) state_nx = S_FIN;
      S_FIN:
        if (fin_ready) state_nx = S_SI_CLR;
      S_SI_CLR:
        if (wr_done) state_nx = S_SI_BR;
      S_SI_BR:
        if (b_hs) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      k         <= '0;
      nslots    <= '0;
      tid_q     <= '0;
      ptid_q    <= '0;
      type_q    <= '0;
      pay_q     <= '0;
      nargs_q   <= '0;
      ndeps_q   <= '0;
      ncops_q   <= '0;
      so_idx    <= '0;
      si_idx    <= '0;
      si_turn   <= 1'b0;
      ar_sent   <= 1'b0;
      addr_sent <= 1'b0;
      data_sent <= 1'b0;
      gap_cnt   <= '0;
      err       <= 1'b0;
      fin_tid   <= '0;
      fin_ptid  <= '0;
    end else begin
      if (r_hs)       ar_sent <= 1'b0;
      else if (ar_hs) ar_sent <= 1'b1;

      if (wr_st && wr_done) begin
        addr_sent <= 1'b0;
        data_sent <= 1'b0;
      end else begin
        if (aw_hs) addr_sent <= 1'b1;
        if (w_hs)  data_sent <= 1'b1;
      end

      if ((r_hs && m_axi_rresp != 2'b00) ||
          (b_hs && m_axi_bresp != 2'b00))
        err <= 1'b1;

      if (poll_miss)
        gap_cnt <= GAP_LD;
      else if (gap_cnt != 16'd0)
        gap_cnt <= gap_cnt - 16'd1;

      unique case (state)
        S_TASK_LATCH: begin
          tid_q   <= task_tid;
          ptid_q  <= task_ptid;
          type_q  <= task_type;
          nargs_q <= task_nargs;
          ndeps_q <= task_ndeps;
          ncops_q <= task_ncops;
          nslots  <= 11'd4 + 11'(task_nargs) +
            11'(task_ndeps) + {2'b00, task_ncops, 1'b0};
          k       <= 11'd1;
        end
        S_PAY_GET:
          if (pay_valid) pay_q <= pay_data;
        S_SO_BR:
          if (b_hs && k != nslots - 11'd1)
            k <= k + 11'd1;
        S_SO_BR_HDR:
          if (b_hs) begin
            so_idx  <= (so_idx + 32'(nslots)) % SO_LEN;
            si_turn <= 1'b1;
          end
        S_SI_RD_HDR:
          if (r_hs && !si_hdr_ok) si_turn <= 1'b0;
        S_SI_RD_TID:
          if (r_hs) fin_tid <= m_axi_rdata;
        S_SI_RD_PTID:
          if (r_hs) fin_ptid <= m_axi_rdata;
        S_SI_BR:
          if (b_hs) begin
            si_idx  <= (si_idx + 32'd3) % SI_LEN;
            si_turn <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spawn_task_issuer.sv
// tb_spawn_task_issuer: directed + randomized bench for spawn_task_issuer
// with a host-memory AXI4-Lite slave and a ring-level reference model.
module tb_spawn_task_issuer;
  localparam logic [31:0] SO_OFF = 32'h1000;
  localparam logic [31:0] SI_OFF = 32'h2000;
  localparam int SO_N = 8;
  localparam int SI_N = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        task_valid = 1'b0;
  logic        task_ready;
  logic [63:0] task_tid = '0, task_ptid = '0, task_type = '0;
  logic [7:0]  task_nargs = '0, task_ndeps = '0, task_ncops = '0;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic [63:0] pay_data = '0;
  logic        fin_valid;
  logic        fin_ready = 1'b0;
  logic [63:0] fin_tid, fin_ptid;
  logic        err, busy;
  logic [31:0] m_axi_araddr, m_axi_awaddr;
  logic [2:0]  m_axi_arprot, m_axi_awprot;
  logic        m_axi_arvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0;
  logic        m_axi_bvalid = 1'b0;
  logic [63:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0, m_axi_bresp = '0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;

  always #5 clk = ~clk;

  spawn_task_issuer #(
    .SO_OFFSET(SO_OFF), .SI_OFFSET(SI_OFF),
    .SO_LEN(SO_N), .SI_LEN(SI_N), .POLL_GAP(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .task_valid(task_valid), .task_ready(task_ready),
    .task_tid(task_tid), .task_ptid(task_ptid),
    .task_type(task_type), .task_nargs(task_nargs),
    .task_ndeps(task_ndeps), .task_ncops(task_ncops),
    .pay_valid(pay_valid), .pay_ready(pay_ready),
    .pay_data(pay_data),
    .fin_valid(fin_valid), .fin_ready(fin_ready),
    .fin_tid(fin_tid), .fin_ptid(fin_ptid),
    .err(err), .busy(busy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  // Host memory and slave-side logs
  logic [63:0] mem [logic [31:0]];
  int          busy_cnt [logic [31:0]];
  logic [31:0] rd_q [$];
  logic [31:0] wa_q [$];
  logic [63:0] wd_q [$];
  logic [7:0]  ws_q [$];
  logic        err_arm = 1'b0;
  logic [31:0] err_addr = '0;

  int n_assert = 0;
  int n_fail = 0;
  int so_m = 0;
  int si_m = 0;

  logic [31:0] rd_a, aw_a;
  logic [63:0] w_d, cur;
  logic [7:0]  w_s;
  logic        have_aw = 1'b0, have_w = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_axi_arready <= 1'b0;
      m_axi_rvalid  <= 1'b0;
    end else begin
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        rd_a = m_axi_araddr;
        rd_q.push_back(rd_a);
        m_axi_arready <= 1'b0;
        m_axi_rvalid  <= 1'b1;
        m_axi_rresp   <= 2'b00;
        if (busy_cnt.exists(rd_a) && busy_cnt[rd_a] != 0) begin
          busy_cnt[rd_a] = busy_cnt[rd_a] - 1;
          m_axi_rdata <= 64'h80 << 56;
        end else begin
          m_axi_rdata <= mem.exists(rd_a) ? mem[rd_a] : 64'h0;
        end
      end else if (!m_axi_rvalid) begin
        m_axi_arready <= ($urandom_range(0, 3) != 0);
      end
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_axi_awready <= 1'b0;
      m_axi_wready  <= 1'b0;
      m_axi_bvalid  <= 1'b0;
      have_aw = 1'b0;
      have_w  = 1'b0;
    end else begin
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_awvalid && m_axi_awready) begin
        have_aw = 1'b1;
        aw_a = m_axi_awaddr;
        m_axi_awready <= 1'b0;
      end else if (!have_aw && !m_axi_bvalid) begin
        m_axi_awready <= ($urandom_range(0, 1) != 0);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        have_w = 1'b1;
        w_d = m_axi_wdata;
        w_s = m_axi_wstrb;
        m_axi_wready <= 1'b0;
      end else if (!have_w && !m_axi_bvalid) begin
        m_axi_wready <= ($urandom_range(0, 1) != 0);
      end
      if (have_aw && have_w) begin
        cur = mem.exists(aw_a) ? mem[aw_a] : 64'h0;
        for (int b = 0; b < 8; b++)
          if (w_s[b]) cur[b*8 +: 8] = w_d[b*8 +: 8];
        mem[aw_a] = cur;
        wa_q.push_back(aw_a);
        wd_q.push_back(w_d);
        ws_q.push_back(w_s);
        m_axi_bvalid <= 1'b1;
        if (err_arm && aw_a == err_addr) begin
          m_axi_bresp <= 2'b10;
          err_arm = 1'b0;
        end else begin
          m_axi_bresp <= 2'b00;
        end
        have_aw = 1'b0;
        have_w  = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    ws_q.delete();
  endtask

  task automatic clear_so();
    for (int i = 0; i < SO_N; i++) mem.delete(SO_OFF + 32'(i * 8));
  endtask

  task automatic wait_wr(input int n);
    int c = 0;
    while (wa_q.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic hs_task(input logic [63:0] tid, ptid, typ,
                         input logic [7:0] na, nd, nc);
    int c = 0;
    @(negedge clk);
    task_valid = 1'b1;
    task_tid = tid; task_ptid = ptid; task_type = typ;
    task_nargs = na; task_ndeps = nd; task_ncops = nc;
    while (!task_ready && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("task_ready", 64'(task_ready), 64'd1);
    @(posedge clk);
    #1 task_valid = 1'b0;
  endtask

  task automatic send_pay(input logic [63:0] w);
    int c = 0;
    pay_valid = 1'b1;
    pay_data = w;
    @(negedge clk);
    while (!pay_ready && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("pay_ready", 64'(pay_ready), 64'd1);
    @(posedge clk);
    #1 pay_valid = 1'b0;
  endtask

  // Reference: slots k1..n-1 in order at (so_idx+k)%LEN, header last.
  task automatic run_task(input string tag,
                          input logic [63:0] tid, ptid, typ,
                          input logic [7:0] na, nd, nc,
                          input logic [63:0] pay [$]);
    logic [31:0] ea [$];
    logic [63:0] ed [$];
    int n;
    n = 4 + int'(na) + int'(nd) + 2 * int'(nc);
    for (int k = 1; k < n; k++) begin
      ea.push_back(SO_OFF + 32'(((so_m + k) % SO_N) * 8));
      if (k == 1)      ed.push_back(tid);
      else if (k == 2) ed.push_back(ptid);
      else if (k == 3) ed.push_back(typ);
      else             ed.push_back(pay[k - 4]);
    end
    ea.push_back(SO_OFF + 32'(so_m * 8));
    ed.push_back({8'h80, 24'h0, nc, nd, na, 8'h00});
    clear_logs();
    hs_task(tid, ptid, typ, na, nd, nc);
    for (int i = 0; i < n - 4; i++) send_pay(pay[i]);
    wait_wr(n);
    chk({tag, " nwr"}, 64'(wa_q.size()), 64'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk($sformatf("%s addr%0d", tag, i), 64'(wa_q[i]), 64'(ea[i]));
      chk($sformatf("%s data%0d", tag, i), wd_q[i], ed[i]);
      chk($sformatf("%s strb%0d", tag, i), 64'(ws_q[i]), 64'hFF);
    end
    so_m = (so_m + n) % SO_N;
  endtask

  task automatic run_fin(input string tag, input logic [63:0] t, p,
                         input int hold);
    logic [31:0] a;
    int c = 0;
    a = SI_OFF + 32'(si_m * 8);
    clear_logs();
    @(negedge clk);
    mem[SI_OFF + 32'(((si_m + 1) % SI_N) * 8)] = t;
    mem[SI_OFF + 32'(((si_m + 2) % SI_N) * 8)] = p;
    mem[a] = 64'h80 << 56;
    while (!fin_valid && c < 2000) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < hold; i++) begin
      chk({tag, " fin_valid"}, 64'(fin_valid), 64'd1);
      chk({tag, " fin_tid"}, fin_tid, t);
      @(negedge clk);
    end
    chk({tag, " fin_valid"}, 64'(fin_valid), 64'd1);
    chk({tag, " fin_ptid"}, fin_ptid, p);
    chk({tag, " fin_tid"}, fin_tid, t);
    fin_ready = 1'b1;
    @(posedge clk);
    #1 fin_ready = 1'b0;
    wait_wr(1);
    chk({tag, " clr nwr"}, 64'(wa_q.size()), 64'd1);
    if (wa_q.size() >= 1) begin
      chk({tag, " clr addr"}, 64'(wa_q[0]), 64'(a));
      chk({tag, " clr data"}, wd_q[0], 64'h0);
      chk({tag, " clr strb"}, 64'(ws_q[0]), 64'h80);
    end
    chk({tag, " hdr cleared"}, mem[a], 64'h0);
    si_m = (si_m + 3) % SI_N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pq [$];
    logic [31:0] a3;
    int cnt, c;
    logic [7:0] na, nd, nc;

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst valids", 64'({m_axi_arvalid, m_axi_awvalid,
      m_axi_wvalid, fin_valid, task_ready, pay_ready,
      m_axi_rready, m_axi_bready}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Single-arg task into an empty ring
    pq = {};
    pq.push_back(64'h0000_0000_0000_A5A5);
    run_task("t1", 64'hA, 64'h5, 64'h77, 8'd1, 8'd0, 8'd0, pq);
    if (wa_q.size() == 5) begin
      chk("t1 first addr", 64'(wa_q[0]), 64'(SO_OFF + 32'd8));
      chk("t1 hdr addr", 64'(wa_q[4]), 64'(SO_OFF));
      chk("t1 hdr data", wd_q[4], 64'h8000_0000_0000_0100);
    end
    clear_so();

    // Wrapping task: header slot 5, payload lands in slot 1
    pq = {};
    pq.push_back(64'h1234_5678_9ABC_DEF0);
    run_task("t2", 64'hB, 64'hA, 64'h3, 8'd1, 8'd0, 8'd0, pq);
    if (wa_q.size() == 5) begin
      chk("t2 k4 addr", 64'(wa_q[3]), 64'(SO_OFF + 32'd8));
      chk("t2 hdr addr", 64'(wa_q[4]), 64'(SO_OFF + 32'd40));
    end
    clear_so();

    // Slot k2 busy twice before it frees up
    a3 = SO_OFF + 32'(((so_m + 2) % SO_N) * 8);
    busy_cnt[a3] = 2;
    pq = {};
    pq.push_back(64'hCAFE);
    run_task("t3", 64'hC, 64'hB, 64'h4, 8'd1, 8'd0, 8'd0, pq);
    cnt = 0;
    foreach (rd_q[i]) if (rd_q[i] == a3) cnt++;
    chk("t3 k2 reads", 64'(cnt), 64'd3);
    clear_so();

    // Completion held by a slow consumer
    run_fin("t4", 64'h11, 64'h22, 10);
    run_fin("t4b", 64'h33, 64'h44, 2);

    // Error response on the payload write
    chk("t5 err before", 64'(err), 64'd0);
    err_addr = SO_OFF + 32'(((so_m + 4) % SO_N) * 8);
    err_arm = 1'b1;
    pq = {};
    pq.push_back(64'hDEAD);
    pq.push_back(64'hBEEF);
    run_task("t5", 64'hD, 64'hC, 64'h5, 8'd1, 8'd1, 8'd0, pq);
    chk("t5 err set", 64'(err), 64'd1);
    clear_so();
    pq = {};
    run_task("t5b", 64'hE, 64'hD, 64'h6, 8'd0, 8'd0, 8'd0, pq);
    chk("t5 err sticky", 64'(err), 64'd1);
    clear_so();

    // Reset while waiting for payload
    clear_logs();
    hs_task(64'hF, 64'hE, 64'h7, 8'd2, 8'd0, 8'd0);
    c = 0;
    while (!pay_ready && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("t6 in pay_get", 64'(pay_ready), 64'd1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("t6 valids", 64'({m_axi_arvalid, m_axi_awvalid,
      m_axi_wvalid, fin_valid, task_ready, pay_ready,
      m_axi_rready, m_axi_bready}), 64'd0);
    chk("t6 busy", 64'(busy), 64'd0);
    chk("t6 err", 64'(err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    clear_so();
    so_m = 0;
    si_m = 0;
    pq = {};
    pq.push_back(64'h600D);
    run_task("t6 restart", 64'h99, 64'h98, 64'h1, 8'd1, 8'd0,
      8'd0, pq);
    clear_so();

    // Randomized tasks and completions
    for (int it = 0; it < 8; it++) begin
      na = 8'($urandom_range(0, 1));
      nd = 8'($urandom_range(0, 1));
      nc = 8'($urandom_range(0, 1));
      pq = {};
      for (int j = 0; j < int'(na) + int'(nd) + 2 * int'(nc); j++)
        pq.push_back({$urandom, $urandom});
      run_task($sformatf("r%0d", it), {$urandom, $urandom},
        {$urandom, $urandom}, {$urandom, $urandom}, na, nd, nc, pq);
      clear_so();
      if ($urandom_range(0, 1) != 0)
        run_fin($sformatf("rf%0d", it), {$urandom, $urandom},
          {$urandom, $urandom}, $urandom_range(0, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_assert, n_fail);
    $finish;
  end

endmodule
